// File: rtl/axi4_resp_monitor_pkg.sv
// Shared types and constants for the AXI4 response-side monitor.
// The optional error-response flag is enabled by defining AXI4_RESP_MON_ERR_EN.
package axi4_resp_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HUNG = 2'd2
  } mon_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR are the only codes with the upper bit set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi4_resp_monitor_if.sv
// AXI4 handshake/response signals observed by the response monitor.
// master/slave modports describe the real bus; monitor is the passive tap.
interface axi4_resp_monitor_if;
  logic       axi_arvalid, axi_arready;
  logic       axi_rvalid, axi_rready, axi_rlast;
  logic [1:0] axi_rresp;
  logic       axi_awvalid, axi_awready;
  logic       axi_bvalid, axi_bready;
  logic [1:0] axi_bresp;

  modport master (
    output axi_arvalid, axi_awvalid, axi_rready, axi_bready,
    input  axi_arready, axi_awready, axi_rvalid, axi_rlast, axi_rresp,
           axi_bvalid, axi_bresp
  );

  modport slave (
    input  axi_arvalid, axi_awvalid, axi_rready, axi_bready,
    output axi_arready, axi_awready, axi_rvalid, axi_rlast, axi_rresp,
           axi_bvalid, axi_bresp
  );

  modport monitor (
    input axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast,
          axi_rresp, axi_awvalid, axi_awready, axi_bvalid, axi_bready,
          axi_bresp
  );
endinterface

// File: rtl/axi4_outstanding_ctr.sv
// Saturating inc/dec counter of outstanding transactions for one direction.
// ovf/udf pulse when a step would leave the range [0, MAX_OUTSTANDING].
module axi4_outstanding_ctr #(
  parameter  int MAX_OUTSTANDING = 16,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             udf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  // A simultaneous inc and dec cancel, so neither can overflow nor underflow.
  assign ovf = inc && !dec && (cnt == CNT_MAX);
  assign udf = dec && !inc && (cnt == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of process ordering in simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (inc && !dec && !ovf) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && !udf) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/axi4_resp_monitor.sv
// Passive AXI4 response monitor: outstanding counts, hang watchdog, sticky flags.
// Define AXI4_RESP_MON_ERR_EN to enable resp_err on SLVERR/DECERR responses.
module axi4_resp_monitor
  import axi4_resp_monitor_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 16,
  parameter  int TIMEOUT_CYCLES  = 25_000_000,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  axi4_resp_monitor_if.monitor axi,
  input  logic                 clear,
  output logic [CNT_W-1:0]     rd_outstanding,
  output logic [CNT_W-1:0]     wr_outstanding,
  output logic                 hung,
  output logic                 resp_err,
  output logic                 ovf,
  output logic                 udf,
  output logic                 LED
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic ar_hs, r_hs, r_last_hs, aw_hs, b_hs;
  logic rd_ovf, rd_udf, wr_ovf, wr_udf;
  logic total_zero;
  logic hung_set;
  logic [WD_W-1:0] wd_cnt;
  mon_state_e state, state_next;

  assign ar_hs     = axi.axi_arvalid && axi.axi_arready;
  assign r_hs      = axi.axi_rvalid && axi.axi_rready;
  assign r_last_hs = r_hs && axi.axi_rlast;
  assign aw_hs     = axi.axi_awvalid && axi.axi_awready;
  assign b_hs      = axi.axi_bvalid && axi.axi_bready;

  axi4_outstanding_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_rd_ctr (
    .clk(clk), .reset_n(reset_n), .inc(ar_hs), .dec(r_last_hs),
    .cnt(rd_outstanding), .ovf(rd_ovf), .udf(rd_udf)
  );

  axi4_outstanding_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_wr_ctr (
    .clk(clk), .reset_n(reset_n), .inc(aw_hs), .dec(b_hs),
    .cnt(wr_outstanding), .ovf(wr_ovf), .udf(wr_udf)
  );

  assign total_zero = (rd_outstanding == '0) && (wr_outstanding == '0);

  // Watchdog holds at the limit once reached; the FSM only needs ">= limit",
  // and holding avoids a wrap back below it while the slave stays silent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (r_hs || b_hs || total_zero) begin
      wd_cnt <= '0;
    end else if (wd_cnt < WD_LIMIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // NOTE: defaults first, so every path assigns every output and no latch forms.
  always_comb begin
    state_next = state;
    hung_set   = 1'b0;
    unique case (state)
      S_IDLE: if (!total_zero) state_next = S_BUSY;
      S_BUSY: begin
        if (total_zero) begin
          state_next = S_IDLE;
        end else if (wd_cnt >= WD_LIMIT) begin
          state_next = S_HUNG;
          hung_set   = 1'b1;
        end
      end
      S_HUNG: begin
        if (total_zero)        state_next = S_IDLE;
        else if (r_hs || b_hs) state_next = S_BUSY;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hung <= 1'b0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      hung <= hung_set || (hung && !clear);
      ovf  <= rd_ovf || wr_ovf || (ovf && !clear);
      udf  <= rd_udf || wr_udf || (udf && !clear);
    end
  end

`ifdef AXI4_RESP_MON_ERR_EN
  logic err_set;
  assign err_set = (r_hs && resp_is_err(axi.axi_rresp)) ||
                   (b_hs && resp_is_err(axi.axi_bresp));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) resp_err <= 1'b0;
    else          resp_err <= err_set || (resp_err && !clear);
  end
`else
  logic unused_resp;
  assign unused_resp = ^{axi.axi_rresp, axi.axi_bresp};
  assign resp_err    = 1'b0;
`endif

  assign LED = (state != S_IDLE);

endmodule

// File: tb/tb_axi4_resp_monitor.sv
// Self-checking bench for axi4_resp_monitor against a transaction-level model.
// Honours AXI4_RESP_MON_ERR_EN for the expected behaviour of resp_err.
module tb_axi4_resp_monitor;
  import axi4_resp_monitor_pkg::*;

  localparam int MAX = 16;
  localparam int TMO = 100;
  localparam int CW  = $clog2(MAX + 1);
`ifdef AXI4_RESP_MON_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic [CW-1:0] rd_outstanding, wr_outstanding;
  logic hung, resp_err, ovf, udf, LED;

  int errors = 0;
  int checks = 0;

  // Reference model: transaction counts, a silence timer and activity phase.
  int m_rd, m_wr, m_silence;
  bit m_active, m_stalled;
  bit m_hung, m_err, m_ovf, m_udf;

  axi4_resp_monitor_if axi_bus ();

  axi4_resp_monitor #(.MAX_OUTSTANDING(MAX), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .axi(axi_bus), .clear(clear),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .hung(hung), .resp_err(resp_err), .ovf(ovf), .udf(udf), .LED(LED)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_silence = 0;
    m_active = 0; m_stalled = 0;
    m_hung = 0; m_err = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic set_idle();
    axi_bus.axi_arvalid = 0; axi_bus.axi_arready = 0;
    axi_bus.axi_rvalid  = 0; axi_bus.axi_rready  = 0; axi_bus.axi_rlast = 0;
    axi_bus.axi_rresp   = RESP_OKAY;
    axi_bus.axi_awvalid = 0; axi_bus.axi_awready = 0;
    axi_bus.axi_bvalid  = 0; axi_bus.axi_bready  = 0;
    axi_bus.axi_bresp   = RESP_OKAY;
    clear = 0;
  endtask

  task automatic set_hs(input bit ar, input bit r, input bit rl, input bit aw, input bit b);
    axi_bus.axi_arvalid = ar; axi_bus.axi_arready = ar;
    axi_bus.axi_rvalid  = r;  axi_bus.axi_rready  = r;  axi_bus.axi_rlast = rl;
    axi_bus.axi_awvalid = aw; axi_bus.axi_awready = aw;
    axi_bus.axi_bvalid  = b;  axi_bus.axi_bready  = b;
  endtask

  // One clock: capture driven inputs, advance the model, settle past the edge.
  task automatic tick();
    bit ar_hs, r_hs, rl_hs, aw_hs, b_hs, clr, hang_now, ovf_ev, udf_ev, err_ev;
    int total;
    ar_hs = axi_bus.axi_arvalid && axi_bus.axi_arready;
    r_hs  = axi_bus.axi_rvalid && axi_bus.axi_rready;
    rl_hs = r_hs && axi_bus.axi_rlast;
    aw_hs = axi_bus.axi_awvalid && axi_bus.axi_awready;
    b_hs  = axi_bus.axi_bvalid && axi_bus.axi_bready;
    clr   = clear;
    err_ev = ERR_EN && ((r_hs && axi_bus.axi_rresp[1]) || (b_hs && axi_bus.axi_bresp[1]));
    @(posedge clk);
    total = m_rd + m_wr;
    hang_now = 0; ovf_ev = 0; udf_ev = 0;
    if (total == 0) begin
      m_active = 0; m_stalled = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (m_stalled) begin
      if (r_hs || b_hs) m_stalled = 0;
    end else if (m_silence >= TMO - 1) begin
      m_stalled = 1; hang_now = 1;
    end
    if (r_hs || b_hs || total == 0) m_silence = 0;
    else                            m_silence = m_silence + 1;
    if (ar_hs && !rl_hs) begin
      if (m_rd == MAX) ovf_ev = 1; else m_rd++;
    end else if (rl_hs && !ar_hs) begin
      if (m_rd == 0) udf_ev = 1; else m_rd--;
    end
    if (aw_hs && !b_hs) begin
      if (m_wr == MAX) ovf_ev = 1; else m_wr++;
    end else if (b_hs && !aw_hs) begin
      if (m_wr == 0) udf_ev = 1; else m_wr--;
    end
    m_hung = hang_now || (m_hung && !clr);
    m_ovf  = ovf_ev   || (m_ovf  && !clr);
    m_udf  = udf_ev   || (m_udf  && !clr);
    m_err  = err_ev   || (m_err  && !clr);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    model_reset();
    #1;
    checks++; if (rd_outstanding !== '0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rd_outstanding); end
    checks++; if (wr_outstanding !== '0) begin errors++; $display("FAIL reset_wr: got %0d want 0", wr_outstanding); end
    checks++; if (hung !== 1'b0) begin errors++; $display("FAIL reset_hung: got %b want 0", hung); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", resp_err); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL reset_udf: got %b want 0", udf); end
    checks++; if (LED !== 1'b0) begin errors++; $display("FAIL reset_led: got %b want 0", LED); end
  endtask

  // AR at cycle 0, R+rlast at cycle 5: rd=1 in cycles 1..5, LED in cycles 2..6.
  task automatic test_single_read();
    for (int k = 0; k <= 6; k++) begin
      set_idle();
      if (k == 0) set_hs(1, 0, 0, 0, 0);
      if (k == 5) set_hs(0, 1, 1, 0, 0);
      tick();
      checks++;
      if (rd_outstanding !== CW'((k <= 4) ? 1 : 0)) begin
        errors++; $display("FAIL single_rd cycle %0d: got %0d want %0d", k + 1, rd_outstanding, (k <= 4) ? 1 : 0);
      end
      checks++;
      if (LED !== ((k >= 1 && k <= 5) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL single_led cycle %0d: got %b want %b", k + 1, LED, (k >= 1 && k <= 5));
      end
    end
    set_idle(); tick();
  endtask

  task automatic test_burst();
    int want[6] = '{1, 2, 3, 3, 2, 1};
    for (int k = 0; k < 6; k++) begin
      set_idle();
      if (k < 3)       set_hs(0, 0, 0, 1, 0);
      else if (k == 3) set_hs(0, 0, 0, 1, 1);
      else             set_hs(0, 0, 0, 0, 1);
      tick();
      checks++;
      if (wr_outstanding !== CW'(want[k]) || udf !== 1'b0 || ovf !== 1'b0) begin
        errors++; $display("FAIL burst_wr step %0d: got %0d (ovf %b udf %b) want %0d", k, wr_outstanding, ovf, udf, want[k]);
      end
    end
    set_idle(); set_hs(0, 0, 0, 0, 1); tick();
    set_idle(); repeat (2) tick();
    checks++; if (wr_outstanding !== '0 || LED !== 1'b0) begin errors++; $display("FAIL burst_drain: wr %0d led %b want 0 0", wr_outstanding, LED); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 17; k++) begin
      set_idle(); set_hs(1, 0, 0, 0, 0); tick();
      if (k == 15) begin
        checks++; if (rd_outstanding !== CW'(16) || ovf !== 1'b0) begin errors++; $display("FAIL sat_at_max: rd %0d ovf %b want 16 0", rd_outstanding, ovf); end
      end
    end
    checks++; if (rd_outstanding !== CW'(16)) begin errors++; $display("FAIL sat_rd: got %0d want 16", rd_outstanding); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", ovf); end
    set_idle(); set_hs(0, 0, 0, 0, 1); tick();
    checks++; if (udf !== 1'b1 || wr_outstanding !== '0) begin errors++; $display("FAIL sat_udf: udf %b wr %0d want 1 0", udf, wr_outstanding); end
    for (int k = 0; k < 16; k++) begin
      set_idle(); set_hs(0, 1, 1, 0, 0); clear = (k == 0); tick();
    end
    set_idle(); repeat (2) tick();
    checks++;
    if (rd_outstanding !== '0 || ovf !== 1'b0 || udf !== 1'b0 || LED !== 1'b0) begin
      errors++; $display("FAIL sat_drain: rd %0d ovf %b udf %b led %b want 0 0 0 0", rd_outstanding, ovf, udf, LED);
    end
  endtask

  // One AR and silence: hung must first show in cycle 101.
  task automatic test_timeout();
    for (int k = 0; k <= 101; k++) begin
      set_idle();
      if (k == 0) set_hs(1, 0, 0, 0, 0);
      tick();
      if (k >= 95) begin
        checks++;
        if (hung !== ((k >= 100) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL timeout_hung cycle %0d: got %b want %b", k + 1, hung, (k >= 100));
        end
      end
    end
    set_idle(); set_hs(0, 1, 1, 0, 0); tick();
    set_idle(); repeat (2) tick();
    checks++; if (LED !== 1'b0 || rd_outstanding !== '0) begin errors++; $display("FAIL timeout_idle: led %b rd %0d want 0 0", LED, rd_outstanding); end
    checks++; if (hung !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", hung); end
    set_idle(); clear = 1; tick(); set_idle();
    checks++; if (hung !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", hung); end
  endtask

  task automatic test_error_resp();
    set_idle(); set_hs(0, 0, 0, 1, 0); tick();
    set_idle(); set_hs(0, 0, 0, 0, 1); axi_bus.axi_bresp = RESP_SLVERR; tick();
    checks++; if (resp_err !== ERR_EN) begin errors++; $display("FAIL err_slverr: got %b want %b", resp_err, ERR_EN); end
    set_idle(); clear = 1; tick();
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", resp_err); end
    set_idle(); set_hs(1, 0, 0, 1, 0); tick();
    set_idle(); set_hs(0, 0, 0, 0, 1); axi_bus.axi_bresp = RESP_SLVERR; clear = 1; tick();
    checks++; if (resp_err !== ERR_EN) begin errors++; $display("FAIL err_set_wins: got %b want %b", resp_err, ERR_EN); end
    set_idle(); clear = 1; tick();
    set_idle(); set_hs(0, 1, 1, 0, 0); axi_bus.axi_rresp = RESP_DECERR; tick();
    checks++; if (resp_err !== ERR_EN) begin errors++; $display("FAIL err_rdecerr: got %b want %b", resp_err, ERR_EN); end
    set_idle(); set_hs(0, 1, 0, 0, 0); axi_bus.axi_rresp = RESP_EXOKAY; clear = 1; tick();
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL err_exokay: got %b want 0", resp_err); end
    set_idle(); repeat (2) tick();
  endtask

  task automatic test_random();
    logic [2*CW+4:0] got, exp;
    for (int k = 0; k < 400; k++) begin
      axi_bus.axi_arvalid = ($urandom_range(0, 99) < 35);
      axi_bus.axi_arready = ($urandom_range(0, 99) < 70);
      axi_bus.axi_rvalid  = ($urandom_range(0, 99) < 35);
      axi_bus.axi_rready  = ($urandom_range(0, 99) < 70);
      axi_bus.axi_rlast   = ($urandom_range(0, 99) < 60);
      axi_bus.axi_rresp   = 2'($urandom_range(0, 3));
      axi_bus.axi_awvalid = ($urandom_range(0, 99) < 30);
      axi_bus.axi_awready = ($urandom_range(0, 99) < 70);
      axi_bus.axi_bvalid  = ($urandom_range(0, 99) < 30);
      axi_bus.axi_bready  = ($urandom_range(0, 99) < 70);
      axi_bus.axi_bresp   = 2'($urandom_range(0, 3));
      clear               = ($urandom_range(0, 99) < 6);
      tick();
      got = {rd_outstanding, wr_outstanding, hung, resp_err, ovf, udf, LED};
      exp = {CW'(m_rd), CW'(m_wr), m_hung, m_err, m_ovf, m_udf, m_active};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cycle %0d: rd/wr/hung/err/ovf/udf/led got %0d %0d %b %b %b %b %b want %0d %0d %b %b %b %b %b",
                 k, rd_outstanding, wr_outstanding, hung, resp_err, ovf, udf, LED,
                 m_rd, m_wr, m_hung, m_err, m_ovf, m_udf, m_active);
      end
    end
    set_idle();
  endtask

  // Reset asserted between edges must clear outputs before the next edge.
  task automatic test_async_reset();
    set_idle(); clear = 1; tick();
    for (int k = 0; k < 50 && (m_rd != 0 || m_wr != 0); k++) begin
      set_idle(); set_hs(0, 1, 1, 0, 1); tick();
    end
    set_idle();
    for (int k = 0; k < 4; k++) begin set_hs(1, 0, 0, 0, 0); tick(); end
    set_idle(); tick();
    checks++; if (rd_outstanding !== CW'(4) || LED !== 1'b1) begin errors++; $display("FAIL arst_pre: rd %0d led %b want 4 1", rd_outstanding, LED); end
    #2 reset_n = 0;
    #1;
    checks++; if (rd_outstanding !== '0 || wr_outstanding !== '0) begin errors++; $display("FAIL arst_counters: rd %0d wr %0d want 0 0", rd_outstanding, wr_outstanding); end
    checks++; if (LED !== 1'b0) begin errors++; $display("FAIL arst_led: got %b want 0", LED); end
    @(posedge clk);
    #1 reset_n = 1;
    model_reset();
    set_hs(0, 1, 1, 0, 0); tick();
    checks++; if (udf !== 1'b1 || rd_outstanding !== '0) begin errors++; $display("FAIL arst_udf: udf %b rd %0d want 1 0", udf, rd_outstanding); end
    set_idle(); tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_read();
    test_burst();
    test_saturation();
    test_timeout();
    test_error_resp();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_resp_monitor.md
# axi4_resp_monitor

Passive monitor for one AXI4 slot that observes the response end of the protocol, alongside the address-channel activity monitor. It counts outstanding reads (AR handshake to R handshake with RLAST) and outstanding writes (AW handshake to B handshake). It flags a hung slave when no response arrives within a timeout, and flags error responses. Intended for debug LEDs and status registers on the Ultra96 proxy design.

## Interface
Parameters:
- MAX_OUTSTANDING, 16: counter saturation limit per direction.
- TIMEOUT_CYCLES, 25_000_000: response-silence cycles before hang is declared.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; **one clock; reset is asynchronous and active-low.**
- axi_arvalid, axi_arready  in  1  read address handshake.
- axi_rvalid, axi_rready, axi_rlast  in  1  read data handshake and last beat.
- axi_rresp  in  2  read response code.
- axi_awvalid, axi_awready  in  1  write address handshake.
- axi_bvalid, axi_bready  in  1  write response handshake.
- axi_bresp  in  2  write response code.
- clear  in  1  clears all sticky flags.
- rd_outstanding  out  CNT_W  outstanding reads, CNT_W = $clog2(MAX_OUTSTANDING+1).
- wr_outstanding  out  CNT_W  outstanding writes.
- hung  out  1  sticky; timeout reached.
- resp_err  out  1  sticky; SLVERR/DECERR seen.
- ovf  out  1  sticky; increment attempted at MAX_OUTSTANDING.
- udf  out  1  sticky; decrement attempted at 0.
- LED  out  1  high while any transaction is outstanding.

## Operation
- Handshake = valid && ready, sampled at posedge clk.
- Read counter: +1 on AR handshake; −1 on R handshake with rlast=1. Both in the same cycle: value unchanged, no flags.
- Write counter: +1 on AW handshake; −1 on B handshake. Both in the same cycle: unchanged.
- At MAX_OUTSTANDING, an increment holds the value and sets ovf. At 0, a decrement holds 0 and sets udf.
- Watchdog counter, width $clog2(TIMEOUT_CYCLES)+1:
  - cleared on any R handshake (any beat), on any B handshake, or while the total outstanding count is 0.
  - otherwise increments.
- States (pkg enum): S_IDLE, S_BUSY, S_HUNG.
  - S_IDLE→S_BUSY when the registered total becomes nonzero.
  - S_BUSY→S_IDLE when the total is 0.
  - S_BUSY→S_HUNG when watchdog ≥ TIMEOUT_CYCLES−1; this also sets hung.
  - S_HUNG→S_BUSY on any R/B handshake while total is still nonzero.
  - S_HUNG→S_IDLE when total is 0.
- LED = (state != S_IDLE).
- Sticky flags: set by their event; cleared by clear. If set and clear happen in the same cycle, set wins.

## Timing
- Reset values: counters 0, watchdog 0, state S_IDLE, all sticky flags 0, LED 0.
- Counters, flags and state are registered: an update is visible 1 cycle after the handshake edge.
- LED rises 2 cycles after the first AR/AW handshake: counter register first, then state register.
- hung asserts on the cycle after the watchdog reaches TIMEOUT_CYCLES−1, which is TIMEOUT_CYCLES cycles after the last watchdog clear.
- Asynchronous reset mid-transaction returns everything to reset values immediately. Responses to pre-reset requests then produce udf.

## Configuration
- AXI4_RESP_MON_ERR_EN defined: resp_err sets on an R handshake with rresp[1]=1 or a B handshake with bresp[1]=1.
- Not defined: resp_err is tied 0. axi_rresp and axi_bresp remain as ports but are unused.

## Structure
- axi4_resp_monitor_pkg holds:
  - the state enum.
  - response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- Sub-module axi4_outstanding_ctr: an inc/dec saturating counter with ovf/udf pulse outputs. It is instantiated twice, once for read and once for write.

## Test plan
- Single read: AR handshake at cycle 0, R with rlast at cycle 5 → rd_outstanding 1 during cycles 1–5, back to 0 at cycle 6; LED high cycles 2–6.
- Burst: 3 AW handshakes, then B handshake and AW handshake in the same cycle → wr_outstanding goes 3→3, then 2 B handshakes → 1.
- Saturation: 17 AR handshakes with MAX_OUTSTANDING=16 → rd_outstanding=16, ovf=1. A B handshake with wr=0 → udf=1, wr stays 0.
- Timeout: TIMEOUT_CYCLES=100, one AR with no response → hung=1 at cycle 101; a later R with rlast → state S_IDLE, hung stays 1 until clear.
- Error responses: bresp=2'b10 on a B handshake → resp_err=1 with the macro defined, 0 without. clear asserted in the same cycle as a new SLVERR → resp_err stays 1.
- Reset: assert reset_n=0 while 4 reads are outstanding → counters 0 and LED 0 without waiting for a clock edge.
